// File: rtl/gpzda_sentence_ctrl.sv
// GPZDA sentence controller: header match, BCD time/date capture,
// XOR checksum check, one-cycle valid/error pulses.
module gpzda_sentence_ctrl #(
  parameter int MAX_LEN = 82
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  data,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic [7:0]  day,
  output logic [7:0]  month,
  output logic [15:0] year
);

  localparam int LW = $clog2(MAX_LEN + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FIELDS,
    S_CS_HI,
    S_CS_LO
  } state_t;

  state_t r_state, w_next;

  logic [2:0]    r_hidx;
  logic [7:0]    r_xor;
  logic [LW-1:0] r_len;
  logic [2:0]    r_field;
  logic [2:0]    r_dcnt;
  logic          r_frac;
  logic [3:0]    r_cs_hi;
  logic [23:0]   r_sh_time;
  logic [7:0]    r_sh_day;
  logic [7:0]    r_sh_mon;
  logic [15:0]   r_sh_year;
  logic          r_valid;
  logic          r_error;
  logic [2:0]    r_code;
  logic [7:0]    r_hour, r_min, r_sec;
  logic [7:0]    r_day, r_mon;
  logic [15:0]   r_year;

  logic       w_dollar, w_comma, w_star, w_dot;
  logic       w_digit, w_hex;
  logic [3:0] w_nib;
  logic [7:0] w_ref;
  logic       w_hmatch;
  logic       w_in_sent;
  logic       w_ovf;
  logic       w_cnt_ok;
  logic       w_fld_bad;
  logic       w_fmt_bad;
  logic       w_cs_ok;
  logic       w_set_valid;
  logic       w_set_err;
  logic [2:0] w_code;
  logic       w_int_digit;

  assign w_dollar = (data == 8'h24);
  assign w_comma  = (data == 8'h2C);
  assign w_star   = (data == 8'h2A);
  assign w_dot    = (data == 8'h2E);
  assign w_digit  = (data >= 8'h30) && (data <= 8'h39);
  assign w_hex    = w_digit ||
                    ((data >= 8'h41) && (data <= 8'h46));
  assign w_nib    = w_digit ? data[3:0]
                            : 4'(data[3:0] + 4'd9);

  assign w_hmatch  = (data == w_ref);
  assign w_in_sent = (r_state == S_FIELDS) ||
                     (r_state == S_CS_HI) ||
                     (r_state == S_CS_LO);
  assign w_ovf     = (r_len >= LW'(MAX_LEN));
  assign w_cs_ok   = ({r_cs_hi, w_nib} == r_xor);

  // Fractional seconds digits are skipped, not counted
  assign w_int_digit = w_digit &&
                       !((r_field == 3'd1) && r_frac);

  assign busy     = (r_state != S_IDLE);
  assign valid    = r_valid;
  assign error    = r_error;
  assign err_code = r_code;
  assign hour     = r_hour;
  assign minute   = r_min;
  assign second   = r_sec;
  assign day      = r_day;
  assign month    = r_mon;
  assign year     = r_year;

  // Reference header byte for the comparer position
  always_comb begin
    w_ref = 8'h24;
    case (r_hidx)
      3'd1:    w_ref = 8'h47;
      3'd2:    w_ref = 8'h50;
      3'd3:    w_ref = 8'h5A;
      3'd4:    w_ref = 8'h44;
      3'd5:    w_ref = 8'h41;
      default: w_ref = 8'h24;
    endcase
  end

  // Required digit count for the field being closed
  always_comb begin
    w_cnt_ok = 1'b1;
    case (r_field)
      3'd1:    w_cnt_ok = (r_dcnt == 3'd6);
      3'd2:    w_cnt_ok = (r_dcnt == 3'd2);
      3'd3:    w_cnt_ok = (r_dcnt == 3'd2);
      3'd4:    w_cnt_ok = (r_dcnt == 3'd4);
      default: w_cnt_ok = 1'b1;
    endcase
  end

  // Format violation for the current byte
  always_comb begin
    w_fld_bad = 1'b0;
    unique case (1'b1)
      w_comma: w_fld_bad = !w_cnt_ok;
      w_star:  w_fld_bad = !w_cnt_ok ||
                           (r_field != 3'd6);
      w_dot:   w_fld_bad = (r_field == 3'd1) ? r_frac
                           : (r_field <= 3'd4);
      w_digit: w_fld_bad = (r_field == 3'd0);
      default: w_fld_bad = (r_field <= 3'd4);
    endcase
    w_fmt_bad = (r_state == S_FIELDS) ? w_fld_bad
                                      : !w_hex;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (load) begin
      if (w_dollar) begin
        w_next = S_HEADER;
      end else begin
        case (r_state)
          S_IDLE: w_next = S_IDLE;
          S_HEADER: begin
            if (!w_hmatch)
              w_next = S_IDLE;
            else if (r_hidx == 3'd5)
              w_next = S_FIELDS;
          end
          default: begin
            if (w_ovf || w_fmt_bad)
              w_next = S_IDLE;
            else if (r_state == S_CS_LO)
              w_next = S_IDLE;
            else if (r_state == S_CS_HI)
              w_next = S_CS_LO;
            else if (w_star)
              w_next = S_CS_HI;
          end
        endcase
      end
    end
  end

  // Pulse decisions, highest-priority reason wins
  always_comb begin
    w_set_valid = 1'b0;
    w_set_err   = 1'b0;
    w_code      = 3'd0;
    if (load && w_in_sent) begin
      if (w_dollar) begin
        w_set_err = 1'b1;
        w_code    = 3'd4;
      end else if (w_ovf) begin
        w_set_err = 1'b1;
        w_code    = 3'd3;
      end else if (w_fmt_bad) begin
        w_set_err = 1'b1;
        w_code    = 3'd2;
      end else if (r_state == S_CS_LO) begin
        if (w_cs_ok) begin
          w_set_valid = 1'b1;
        end else begin
          w_set_err = 1'b1;
          w_code    = 3'd1;
        end
      end
    end
  end

  // Datapath: counters, checksum, shadows, outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hidx    <= '0;
      r_xor     <= '0;
      r_len     <= '0;
      r_field   <= '0;
      r_dcnt    <= '0;
      r_frac    <= 1'b0;
      r_cs_hi   <= '0;
      r_sh_time <= '0;
      r_sh_day  <= '0;
      r_sh_mon  <= '0;
      r_sh_year <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= '0;
      r_hour    <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_day     <= '0;
      r_mon     <= '0;
      r_year    <= '0;
    end else begin
      r_valid <= w_set_valid;
      r_error <= w_set_err;
      r_code  <= w_code;
      if (w_set_valid) begin
        r_hour <= r_sh_time[23:16];
        r_min  <= r_sh_time[15:8];
        r_sec  <= r_sh_time[7:0];
        r_day  <= r_sh_day;
        r_mon  <= r_sh_mon;
        r_year <= r_sh_year;
      end
      if (load) begin
        if (w_dollar) begin
          r_xor  <= '0;
          r_len  <= LW'(1);
          r_hidx <= 3'd1;
        end else if (r_state != S_IDLE) begin
          r_len <= r_len + LW'(1);
          case (r_state)
            S_HEADER: begin
              r_xor   <= r_xor ^ data;
              r_hidx  <= r_hidx + 3'd1;
              r_field <= '0;
              r_dcnt  <= '0;
              r_frac  <= 1'b0;
            end
            S_FIELDS: begin
              if (!w_star)
                r_xor <= r_xor ^ data;
              if (w_comma) begin
                if (r_field != 3'd7)
                  r_field <= r_field + 3'd1;
                r_dcnt <= '0;
                r_frac <= 1'b0;
              end else if (w_dot) begin
                r_frac <= 1'b1;
              end else if (w_int_digit) begin
                if (r_dcnt != 3'd7)
                  r_dcnt <= r_dcnt + 3'd1;
                case (r_field)
                  3'd1: r_sh_time <=
                    {r_sh_time[19:0], data[3:0]};
                  3'd2: r_sh_day <=
                    {r_sh_day[3:0], data[3:0]};
                  3'd3: r_sh_mon <=
                    {r_sh_mon[3:0], data[3:0]};
                  3'd4: r_sh_year <=
                    {r_sh_year[11:0], data[3:0]};
                  default: ;
                endcase
              end
            end
            S_CS_HI: r_cs_hi <= w_nib;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gpzda_sentence_ctrl.sv
// Directed bench for gpzda_sentence_ctrl: valid, checksum,
// foreign traffic, gaps, abort, format, overlong, reset.
module tb_gpzda_sentence_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load;
  logic [7:0]  data;
  logic        busy, valid, error;
  logic [2:0]  err_code;
  logic [7:0]  hour, minute, second, day, month;
  logic [15:0] year;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int exp_nv  = 0;
  int exp_ne  = 0;

  gpzda_sentence_ctrl #(.MAX_LEN(82)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .data     (data),
    .busy     (busy),
    .valid    (valid),
    .error    (error),
    .err_code (err_code),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .day      (day),
    .month    (month),
    .year     (year)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (valid) n_valid++;
    if (error) n_err++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    load = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    load = 1'b0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    load = 1'b1;
    data = b;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic send_rng(input string s, input int from,
                          input int to, input int maxgap);
    for (int i = from; i <= to; i++)
      send_byte(s[i], (maxgap > 0) ?
                $urandom_range(0, maxgap) : 0);
  endtask

  task automatic chk_ok_values(input string tag);
    chk({tag, " hour"},  32'(hour),   32'h20);
    chk({tag, " min"},   32'(minute), 32'h15);
    chk({tag, " sec"},   32'(second), 32'h30);
    chk({tag, " day"},   32'(day),    32'h04);
    chk({tag, " month"}, 32'(month),  32'h07);
    chk({tag, " year"},  32'(year),   32'h2002);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    string s_ok, s_bad, s_bad2, s_rmc, s_gn;
    string s_abort, s_fmt, s_long;
    int n;
    s_ok   = "$GPZDA,201530.00,04,07,2002,00,00*60";
    s_bad  = "$GPZDA,201530.00,04,07,2002,00,00*61";
    s_bad2 = "$GPZDA,123456.00,04,07,2002,00,00*61";
    s_rmc  = "$GPRMC,123519,A,4807.038,N*6A";
    s_gn   = "$GNZDA,201530.00,04,07,2002,00,00*60";
    s_abort = "$GPZDA,2015";
    s_fmt  = "$GPZDA,201530.00,4,07,2002,00,00*60";
    s_long = "$GPZDA,201530.00,04,07,2002,00,";
    while (s_long.len() < 90) s_long = {s_long, "0"};

    reset_n = 1'b0;
    load    = 1'b0;
    data    = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst busy",  32'(busy),     0);
    chk("rst valid", 32'(valid),    0);
    chk("rst error", 32'(error),    0);
    chk("rst code",  32'(err_code), 0);
    chk("rst hour",  32'(hour),     0);
    chk("rst min",   32'(minute),   0);
    chk("rst sec",   32'(second),   0);
    chk("rst day",   32'(day),      0);
    chk("rst month", 32'(month),    0);
    chk("rst year",  32'(year),     0);
    reset_n = 1'b1;
    idle(2);

    // valid sentence, back-to-back bytes
    n = s_ok.len();
    send_rng(s_ok, 0, n - 2, 0);
    chk("ok busy mid", 32'(busy), 1);
    chk("ok no early valid", 32'(valid), 0);
    send_byte(s_ok[n-1], 0);
    chk("ok valid pulse", 32'(valid), 1);
    chk("ok error low", 32'(error), 0);
    chk_ok_values("ok");
    @(negedge clock);
    chk("ok valid one cycle", 32'(valid), 0);
    chk("ok busy idle", 32'(busy), 0);
    idle(2);
    exp_nv++;
    chk("ok n_valid", n_valid, exp_nv);
    chk("ok n_err", n_err, exp_ne);

    // bad checksum, same fields
    n = s_bad.len();
    send_rng(s_bad, 0, n - 2, 0);
    send_byte(s_bad[n-1], 0);
    chk("cs error pulse", 32'(error), 1);
    chk("cs code", 32'(err_code), 1);
    chk("cs valid low", 32'(valid), 0);
    idle(2);
    exp_ne++;
    chk("cs n_err", n_err, exp_ne);
    chk("cs n_valid", n_valid, exp_nv);

    // bad checksum with new fields: outputs must hold
    n = s_bad2.len();
    send_rng(s_bad2, 0, n - 2, 0);
    send_byte(s_bad2[n-1], 0);
    chk("cs2 code", 32'(err_code), 1);
    idle(2);
    exp_ne++;
    chk("cs2 n_err", n_err, exp_ne);
    chk_ok_values("cs2 hold");

    // foreign sentences
    send_rng(s_rmc, 0, 2, 0);
    chk("rmc busy in hdr", 32'(busy), 1);
    send_byte(s_rmc[3], 0);
    chk("rmc busy drop", 32'(busy), 0);
    send_rng(s_rmc, 4, s_rmc.len() - 1, 0);
    send_rng(s_gn, 0, 1, 0);
    chk("gn busy in hdr", 32'(busy), 1);
    send_byte(s_gn[2], 0);
    chk("gn busy drop", 32'(busy), 0);
    send_rng(s_gn, 3, s_gn.len() - 1, 0);
    idle(2);
    chk("foreign n_valid", n_valid, exp_nv);
    chk("foreign n_err", n_err, exp_ne);

    // random load gaps
    do_reset();
    chk("gap pre hour", 32'(hour), 0);
    send_rng(s_ok, 0, s_ok.len() - 1, 5);
    idle(2);
    exp_nv++;
    chk("gap n_valid", n_valid, exp_nv);
    chk("gap n_err", n_err, exp_ne);
    chk_ok_values("gap");

    // abort by '$' then recover
    do_reset();
    send_rng(s_abort, 0, s_abort.len() - 1, 0);
    send_byte(s_ok[0], 0);
    chk("abort error", 32'(error), 1);
    chk("abort code", 32'(err_code), 4);
    chk("abort busy", 32'(busy), 1);
    send_rng(s_ok, 1, s_ok.len() - 1, 0);
    idle(2);
    exp_ne++;
    exp_nv++;
    chk("abort n_err", n_err, exp_ne);
    chk("abort n_valid", n_valid, exp_nv);
    chk_ok_values("abort");

    // short day field
    send_rng(s_fmt, 0, 17, 0);
    send_byte(s_fmt[18], 0);
    chk("fmt error", 32'(error), 1);
    chk("fmt code", 32'(err_code), 2);
    send_rng(s_fmt, 19, s_fmt.len() - 1, 0);
    idle(2);
    exp_ne++;
    chk("fmt n_err", n_err, exp_ne);
    chk("fmt n_valid", n_valid, exp_nv);
    chk("fmt busy", 32'(busy), 0);

    // overlong sentence: byte 83 rejects
    send_rng(s_long, 0, 81, 0);
    idle(2);
    chk("long none at 82", n_err, exp_ne);
    chk("long busy at 82", 32'(busy), 1);
    send_byte(s_long[82], 0);
    chk("long error", 32'(error), 1);
    chk("long code", 32'(err_code), 3);
    send_rng(s_long, 83, s_long.len() - 1, 0);
    idle(2);
    exp_ne++;
    chk("long n_err", n_err, exp_ne);
    chk("long busy", 32'(busy), 0);

    // reset in the middle of the time field
    send_rng(s_abort, 0, s_abort.len() - 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst busy", 32'(busy), 0);
    chk("mrst hour", 32'(hour), 0);
    chk("mrst year", 32'(year), 0);
    chk("mrst day", 32'(day), 0);
    @(negedge clock);
    reset_n = 1'b1;
    send_rng(s_ok, 11, s_ok.len() - 1, 0);
    idle(3);
    chk("mrst n_valid", n_valid, exp_nv);
    chk("mrst n_err", n_err, exp_ne);
    chk("mrst min", 32'(minute), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
